// File: rtl/arp_tx_framer.sv
// ARP request/reply transmit framer: latches one job and streams a 60-byte
// Ethernet/ARP frame MSB-first on a valid/ready/last byte interface.
//
// state | meaning
// IDLE  | no frame in progress; jobs may be accepted (reply has priority)
// SEND  | frame streaming; byte index held in cnt, advances on valid&ready
module arp_tx_framer #(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic        trig_arp_qvalid_in,
  input  logic [31:0] trig_arp_ip_in,
  output logic        trig_arp_qready_out,
  input  logic        arp_reply_valid_in,
  input  logic [47:0] arp_reply_mac_in,
  input  logic [31:0] arp_reply_ip_in,
  output logic        arp_reply_ready_out,
  output logic [7:0]  arp_tx_data_out,
  output logic        arp_tx_valid_out,
  input  logic        arp_tx_ready_in,
  output logic        arp_tx_last_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SEND  = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'd59;

  logic [0:0]  state;
  logic        armed;
  logic [5:0]  cnt;
  logic [5:0]  cnt_inc;
  logic        op_reply;
  logic [47:0] dst_mac;
  logic [47:0] tha;
  logic [31:0] tpa;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        last_q;

  logic        accept_reply;
  logic        accept_req;
  logic        nxt_reply;
  logic [47:0] nxt_dst;
  logic [47:0] nxt_tha;
  logic [31:0] nxt_tpa;

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] k);
    logic [7:0] b;
    b = 8'h00;
    case (k)
      3'd0:    b = m[47:40];
      3'd1:    b = m[39:32];
      3'd2:    b = m[31:24];
      3'd3:    b = m[23:16];
      3'd4:    b = m[15:8];
      3'd5:    b = m[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [1:0] k);
    logic [7:0] b;
    b = 8'h00;
    case (k)
      2'd0:    b = a[31:24];
      2'd1:    b = a[23:16];
      2'd2:    b = a[15:8];
      default: b = a[7:0];
    endcase
    return b;
  endfunction

  // Byte at frame position idx for the given job fields; bytes 42..59 are pad.
  function automatic logic [7:0] frame_byte(
    input logic [5:0]  idx,
    input logic [47:0] dst,
    input logic        is_reply,
    input logic [47:0] tha_v,
    input logic [31:0] tpa_v
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx <= 6'd5) begin
      b = mac_byte(dst, 3'(idx));
    end else if (idx <= 6'd11) begin
      b = mac_byte(LOCAL_MAC, 3'(idx - 6'd6));
    end else if (idx <= 6'd21) begin
      case (idx)
        6'd12:   b = 8'h08;
        6'd13:   b = 8'h06;
        6'd14:   b = 8'h00;
        6'd15:   b = 8'h01;
        6'd16:   b = 8'h08;
        6'd17:   b = 8'h00;
        6'd18:   b = 8'h06;
        6'd19:   b = 8'h04;
        6'd20:   b = 8'h00;
        default: b = is_reply ? 8'h02 : 8'h01;
      endcase
    end else if (idx <= 6'd27) begin
      b = mac_byte(LOCAL_MAC, 3'(idx - 6'd22));
    end else if (idx <= 6'd31) begin
      b = ip_byte(LOCAL_IP, 2'(idx - 6'd28));
    end else if (idx <= 6'd37) begin
      b = mac_byte(tha_v, 3'(idx - 6'd32));
    end else if (idx <= 6'd41) begin
      b = ip_byte(tpa_v, 2'(idx - 6'd38));
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // armed keeps both readies low until the first edge after reset release
  assign arp_reply_ready_out = armed & (state == ST_IDLE);
  assign trig_arp_qready_out = armed & (state == ST_IDLE) & ~arp_reply_valid_in;

  assign accept_reply = arp_reply_ready_out & arp_reply_valid_in;
  assign accept_req   = trig_arp_qready_out & trig_arp_qvalid_in;
  assign cnt_inc      = cnt + 6'd1;

  always_comb begin
    nxt_reply = 1'b0;
    nxt_dst   = 48'hFFFF_FFFF_FFFF;
    nxt_tha   = 48'h0;
    nxt_tpa   = trig_arp_ip_in;
    if (arp_reply_valid_in) begin
      nxt_reply = 1'b1;
      nxt_dst   = arp_reply_mac_in;
      nxt_tha   = arp_reply_mac_in;
      nxt_tpa   = arp_reply_ip_in;
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      cnt      <= 6'd0;
      op_reply <= 1'b0;
      dst_mac  <= 48'h0;
      tha      <= 48'h0;
      tpa      <= 32'h0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept_reply || accept_req) begin
            op_reply <= nxt_reply;
            dst_mac  <= nxt_dst;
            tha      <= nxt_tha;
            tpa      <= nxt_tpa;
            cnt      <= 6'd0;
            data_q   <= frame_byte(6'd0, nxt_dst, nxt_reply, nxt_tha, nxt_tpa);
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (arp_tx_ready_in) begin
            if (cnt == LAST_IDX) begin
              cnt     <= 6'd0;
              data_q  <= 8'h00;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              cnt    <= cnt_inc;
              data_q <= frame_byte(cnt_inc, dst_mac, op_reply, tha, tpa);
              last_q <= (cnt_inc == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arp_tx_data_out  = data_q;
  assign arp_tx_valid_out = valid_q;
  assign arp_tx_last_out  = last_q;

endmodule

// File: tb/tb_arp_tx_framer.sv
// Randomised bench for arp_tx_framer: a frame-level model (whole frame built as
// one 480-bit vector per accepted job) is compared with the DUT every cycle.
module tb_arp_tx_framer;
  localparam logic [31:0] LIP  = 32'hC0A8_006E;
  localparam logic [47:0] LMAC = 48'hABCD_1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        trig_valid = 1'b0;
  logic [31:0] trig_ip = 32'h0;
  logic        trig_ready;
  logic        reply_valid = 1'b0;
  logic [47:0] reply_mac = 48'h0;
  logic [31:0] reply_ip = 32'h0;
  logic        reply_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;

  int tests = 0;
  int fails = 0;

  arp_tx_framer #(.LOCAL_IP(LIP), .LOCAL_MAC(LMAC)) dut (
    .logic_clk(clk),
    .logic_rst_n(rst_n),
    .trig_arp_qvalid_in(trig_valid),
    .trig_arp_ip_in(trig_ip),
    .trig_arp_qready_out(trig_ready),
    .arp_reply_valid_in(reply_valid),
    .arp_reply_mac_in(reply_mac),
    .arp_reply_ip_in(reply_ip),
    .arp_reply_ready_out(reply_ready),
    .arp_tx_data_out(tx_data),
    .arp_tx_valid_out(tx_valid),
    .arp_tx_ready_in(tx_ready),
    .arp_tx_last_out(tx_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [479:0] build(input bit is_reply, input logic [47:0] mac, input logic [31:0] ip);
    logic [47:0] dst;
    logic [47:0] tha;
    logic [15:0] op;
    dst = is_reply ? mac : 48'hFFFF_FFFF_FFFF;
    tha = is_reply ? mac : 48'h0;
    op  = is_reply ? 16'h0002 : 16'h0001;
    return {dst, LMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, op,
            LMAC, LIP, tha, ip, 144'h0};
  endfunction

  function automatic logic [7:0] fbyte(input logic [479:0] v, input int i);
    return v[479 - 8*i -: 8];
  endfunction

  // Model: bytes still owed by the current frame, plus post-reset arming.
  logic [7:0] exp_q[$];
  bit         m_armed = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [479:0] f;
    if (!rst_n) begin
      exp_q.delete();
      m_armed = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        if (tx_ready) void'(exp_q.pop_front());
      end else if (m_armed && (reply_valid || trig_valid)) begin
        f = reply_valid ? build(1'b1, reply_mac, reply_ip) : build(1'b0, 48'h0, trig_ip);
        for (int i = 0; i < 60; i++) exp_q.push_back(fbyte(f, i));
      end
      m_armed = 1'b1;
    end
  end

  // Per-cycle compare, plus stall-stability and window counters.
  bit         last_seen = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  int         qr_hs = 0;
  int         v_cycles = 0;

  always @(negedge clk) begin
    bit         ev;
    logic [7:0] ed;
    bit         el;
    bit         er;
    ev = exp_q.size() > 0;
    ed = ev ? exp_q[0] : 8'h00;
    el = exp_q.size() == 1;
    er = m_armed && !ev && rst_n;
    chk("valid", tx_valid, ev);
    chk("data", tx_data, ed);
    chk("last", tx_last, el);
    chk("reply_ready", reply_ready, er);
    chk("trig_ready", trig_ready, er && !reply_valid);
    if (prev_stall && rst_n) begin
      chk("stall_data", tx_data, prev_data);
      chk("stall_last", tx_last, prev_last);
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    prev_last  = tx_last;
    if (tx_valid && tx_last && tx_ready) last_seen = 1'b1;
    if (trig_ready && trig_valid) qr_hs++;
    if (tx_valid) v_cycles++;
  end

  bit bp_mode = 1'b0;
  int hold_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (last_seen) begin
      last_seen = 1'b0;
      if (bp_mode) hold_cnt = 64;
    end
    if (!bp_mode) tx_ready = 1'b1;
    else if (hold_cnt > 0) begin
      tx_ready = 1'b0;
      hold_cnt--;
    end else tx_ready = 1'($urandom_range(0, 1));
  end

  task automatic send_req(input logic [31:0] ip, input logic [31:0] ip_after);
    bit done = 1'b0;
    trig_valid = 1'b1;
    trig_ip    = ip;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (trig_ready) begin
        @(posedge clk);
        #1;
        trig_valid = 1'b0;
        trig_ip    = ip_after;
        done       = 1'b1;
      end
    end
    trig_valid = 1'b0;
    chk("req_accepted", done, 1'b1);
  endtask

  task automatic send_reply(input logic [47:0] mac, input logic [31:0] ip);
    bit done = 1'b0;
    reply_valid = 1'b1;
    reply_mac   = mac;
    reply_ip    = ip;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (reply_ready) begin
        @(posedge clk);
        #1;
        reply_valid = 1'b0;
        reply_mac   = 48'h0;
        reply_ip    = 32'h0;
        done        = 1'b1;
      end
    end
    reply_valid = 1'b0;
    chk("reply_accepted", done, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    chk("frame_done", done, 1'b1);
  endtask

  initial begin
    logic [479:0] rq;
    logic [479:0] rp;
    int           pin_idx[8]  = '{0, 11, 13, 21, 31, 38, 41, 59};
    logic [7:0]   pin_req[8]  = '{8'hFF, 8'h78, 8'h06, 8'h01, 8'h6E, 8'hC0, 8'hFF, 8'h00};
    int           rpin_idx[5] = '{0, 5, 21, 37, 41};
    logic [7:0]   pin_rep[5]  = '{8'h00, 8'h55, 8'h02, 8'h55, 8'h01};
    bit           found;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_last", tx_last, 1'b0);
    chk("rst_reply_ready", reply_ready, 1'b0);
    chk("rst_trig_ready", trig_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rq = build(1'b0, 48'h0, 32'hC0A8_00FF);
    rp = build(1'b1, 48'h0011_2233_4455, 32'hC0A8_0001);
    for (int i = 0; i < 8; i++) chk("pin_req", fbyte(rq, pin_idx[i]), pin_req[i]);
    for (int i = 0; i < 5; i++) chk("pin_reply", fbyte(rp, rpin_idx[i]), pin_rep[i]);

    // Request with the input changing after acceptance.
    repeat (2) @(posedge clk);
    #1;
    qr_hs = 0;
    v_cycles = 0;
    send_req(32'hC0A8_00FF, 32'h0A00_0001);
    wait_idle(200);
    chk("req_qready_hs", qr_hs, 1);
    chk("req_valid_cycles", v_cycles, 60);

    send_reply(48'h0011_2233_4455, 32'hC0A8_0001);
    wait_idle(200);

    // Both job types offered together: reply streams first, request second.
    @(posedge clk);
    #1;
    v_cycles = 0;
    fork
      send_reply(48'h0A1B_2C3D_4E5F, 32'h0A00_0002);
      send_req(32'h0A00_0003, 32'h0);
    join
    wait_idle(200);
    chk("arb_valid_cycles", v_cycles, 120);

    bp_mode = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      case ($urandom_range(0, 2))
        0: send_req($urandom, $urandom);
        1: send_reply({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, $urandom);
        default: fork
          send_reply({16'($urandom), $urandom}, $urandom);
          send_req($urandom, $urandom);
        join
      endcase
      wait_idle(3000);
    end
    wait_idle(3000);
    repeat (70) @(posedge clk);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while byte 20 is presented.
    #1;
    send_req(32'hC0A8_00FF, 32'h0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (exp_q.size() == 40) found = 1'b1;
    end
    chk("reached_byte20", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_last", tx_last, 1'b0);
    chk("mid_rst_reply_ready", reply_ready, 1'b0);
    chk("mid_rst_trig_ready", trig_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    v_cycles = 0;
    send_req(32'hC0A8_0042, 32'h0);
    wait_idle(200);
    chk("post_rst_valid_cycles", v_cycles, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/arp_tx_framer.md
# arp_tx_framer

Builds complete 60-byte Ethernet/ARP frames (ARP request or ARP reply) and streams them byte-by-byte on a valid/ready/last interface toward the transmit MAC. It is the transmit-side counterpart of the ARP receive path. The receive parser hands it reply jobs (requester MAC/IP), and the MAC-query logic hands it request jobs (unknown target IP) through the existing `trig_arp_*` handshake.

## Interface
- `LOCAL_IP`, default `32'hC0A8_006E`: local IPv4 address, used as SPA.
- `LOCAL_MAC`, default `48'hABCD_1234_5678`: local MAC, used as the source MAC and as SHA.
- `logic_clk`  in  1  single clock domain; all logic rises on its posedge.
- `logic_rst_n`  in  1  reset; asynchronous, active-low.
- `trig_arp_qvalid_in`  in  1  request job valid.
- `trig_arp_ip_in`  in  32  target IP (TPA) of the request.
- `trig_arp_qready_out`  out  1  request job accepted on `valid&ready`.
- `arp_reply_valid_in`  in  1  reply job valid.
- `arp_reply_mac_in`  in  48  requester MAC; used as destination MAC and THA.
- `arp_reply_ip_in`  in  32  requester IP (TPA).
- `arp_reply_ready_out`  out  1  reply job accepted on `valid&ready`.
- `arp_tx_data_out`  out  8  frame byte.
- `arp_tx_valid_out`  out  1  byte valid.
- `arp_tx_ready_in`  in  1  downstream ready.
- `arp_tx_last_out`  out  1  marks byte 59.

## Operation
- States:
  - IDLE: no frame in progress.
  - SEND: a frame is streaming.
- Byte counter is 6 bits, 0..59.
- Job arbitration, in IDLE only:
  - `arp_reply_ready_out = IDLE`.
  - `trig_arp_qready_out = IDLE & !arp_reply_valid_in`.
  - Reply has priority. Both ready outputs are 0 during SEND and during reset.
- On acceptance:
  - Latch opcode (1 = request, 2 = reply), destination MAC, THA and TPA.
  - Clear the counter and go to SEND.
  - Inputs are don't-care after acceptance.
- Field selection by job type:
  - Request: destination MAC = FF×6, THA = 00×6, TPA = `trig_arp_ip_in`.
  - Reply: destination MAC = THA = `arp_reply_mac_in`, TPA = `arp_reply_ip_in`.
- Frame layout, MSB first (byte index: content):
  - 0-5: destination MAC.
  - 6-11: `LOCAL_MAC`.
  - 12-13: 08 06.
  - 14-15: 00 01.
  - 16-17: 08 00.
  - 18: 06.
  - 19: 04.
  - 20-21: opcode, 00 01 or 00 02.
  - 22-27: `LOCAL_MAC`.
  - 28-31: `LOCAL_IP`.
  - 32-37: THA.
  - 38-41: TPA.
  - 42-59: 00 padding.
- In SEND:
  - `valid_out = 1`.
  - `data_out` is a mux of the counter and latched fields; it is registered-only, with no input-to-output combinational path.
  - `last_out = (cnt == 59)`.
  - Counter advances on `valid&ready`.
  - A handshake at cnt 59 returns the block to IDLE and clears valid/last.
- In IDLE: `data_out = 00`, `valid_out = 0`, `last_out = 0`.
- Reset mid-frame, asynchronously:
  - State goes to IDLE, counter to 0, all outputs to 0.
  - The frame is truncated with no `last`. Downstream discards it.
  - The latched job is lost.

## Timing
- Reset values:
  - `arp_tx_data_out = 00`, `arp_tx_valid_out = 0`, `arp_tx_last_out = 0`.
  - `trig_arp_qready_out = 0`, `arp_reply_ready_out = 0`.
- Latency: job accepted at edge N; byte 0 valid in the cycle after edge N.
- With `arp_tx_ready_in` held high, a frame occupies exactly 60 cycles.
- Backpressure: while `valid & !ready`, data and last hold stable. Ready may toggle every cycle.
- Back-to-back frames: last handshake at edge M; IDLE in cycle M+1, where a pending job is accepted; next byte 0 at M+2. So valid is low for exactly 1 cycle between frames.
- Simultaneous request and reply in IDLE: reply wins. The request stays pending and is served at the first IDLE cycle after the reply frame.
- A reply arriving in the same IDLE cycle as a waiting request preempts that request again.

## Test plan
- **Request frame:** defaults, `trig_arp_ip_in = C0A8_00FF`, ready tied high. Required frame, in order:
  - FF×6, AB CD 12 34 56 78, 08 06, 00 01 08 00 06 04 00 01.
  - AB CD 12 34 56 78, C0 A8 00 6E, 00×6, C0 A8 00 FF, 00×18.
  - `last` asserted only on byte 59; qready high for exactly 1 cycle; valid contiguous for 60 cycles.
- **Reply frame:** MAC 0x0011_2233_4455, IP C0A8_0001. Required:
  - Destination 00 11 22 33 44 55, opcode 00 02, THA 00 11 22 33 44 55, TPA C0 A8 00 01.
  - All other bytes as in the request test.
- **Backpressure:** random ready, plus ready held low for 64 cycles after each last. Required: byte sequence identical to the ready-high case; data/last never change while `valid & !ready`.
- **Arbitration:** both valids asserted in the same cycle. Required: reply frame first, request frame second, exactly 1 valid-low cycle between them.
- **Reset mid-frame:** `logic_rst_n` low at byte 20. Required: valid/last/readies drop to 0 immediately. After release, a new request yields a full 60-byte frame starting at byte 0 (FF).
- **Input latching:** change `trig_arp_ip_in` to 0A00_0001 during the frame. Required: TPA bytes still C0 A8 00 FF.
